msg_sequencer: RTL and testbench
================================

MSG_SEQUENCER -- requirements
Module: msg_sequencer

Interface
REQ-001 Parameter MSG_LEN, default 10: number of ROM characters per message, legal range 1..16.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted between accepted characters, legal range 0..255.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  request to stream one message; sampled only in IDLE.
REQ-006 abort  in  1  terminate the current message; sampled in every non-IDLE state.
REQ-007 rom_addr  out  4  address to the character ROM (combinational ROM, data valid in the same cycle).
REQ-008 rom_data  in  8  ASCII character returned by the ROM.
REQ-009 tx_data  out  8  character offered to the sink.
REQ-010 tx_valid  out  1  tx_data is valid.
REQ-011 tx_ready  in  1  sink accepts tx_data when tx_valid and tx_ready are both high on a rising edge (handshake).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when a message completes normally.
REQ-014 char_count  out  5  number of characters accepted since the last start.

Function
REQ-015 The block SHALL implement the FSM states IDLE, FETCH, SEND, GAP and DONE.
REQ-016 In IDLE, start=1 SHALL clear rom_addr and char_count to 0 and move to FETCH.
REQ-017 In FETCH, the block SHALL register rom_data into tx_data and move to SEND after exactly one cycle.
REQ-018 In SEND, tx_valid SHALL be 1, and tx_data and rom_addr SHALL stay stable until the handshake.
REQ-019 On a SEND handshake, char_count SHALL increment.
REQ-019a If rom_addr==MSG_LEN-1, the next state SHALL be DONE.
REQ-019b Otherwise rom_addr SHALL increment and the next state SHALL be GAP (GAP_CYCLES>0) or FETCH (GAP_CYCLES==0).
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, counted by an 8-bit down-counter, then move to FETCH.
REQ-021 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-022 tx_valid SHALL be 0 in IDLE, FETCH, GAP and DONE.
REQ-023 Latency, start to first tx_valid: exactly 2 cycles (start sampled at edge N, tx_valid high from edge N+2).
REQ-024 With tx_ready held at 1, consecutive tx_valid assertions SHALL be spaced 2+GAP_CYCLES cycles apart.
REQ-025 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with tx_valid low from that edge and no done pulse.
REQ-027 abort has priority over start, handshake and state advance, with one exception: a handshake in the abort cycle still increments char_count.
REQ-028 rom_addr SHALL never exceed MSG_LEN-1, with no wrap-around.
REQ-029 char_count SHALL hold its final value in IDLE until the next accepted start.
REQ-030 MSG_LEN==1: the first handshake SHALL go directly to DONE, with no GAP.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL enter IDLE, with priority over start and abort.
REQ-032 Reset values: rom_addr=0, tx_data=0x00, tx_valid=0, busy=0, done=0, char_count=0, gap counter=0.
REQ-033 Reset asserted mid-message SHALL discard the message with no done pulse, and tx_valid SHALL be 0 at the next edge.

Verification
REQ-034 Defaults, tx_ready=1, start pulsed at cycle 0 -> tx_data sequence 0x41,0x53,0x53,0x49,0x47,0x4E,0x4D,0x45,0x4E,0x54 on cycles 2,6,...,38; done=1 in cycle 39 only; char_count=10; busy=0 from cycle 40.
REQ-035 GAP_CYCLES=0, tx_ready=1 -> tx_valid high in cycles 2,4,...,20; done in cycle 21.
REQ-036 tx_ready low for 5 cycles during the 3rd character -> tx_data held at 0x53 with tx_valid=1 throughout; no character is skipped or duplicated.
REQ-037 abort during GAP after 4 handshakes -> IDLE next cycle; done never pulses; char_count=4; a following start restarts with 0x41.
REQ-038 start re-pulsed during SEND -> no effect on rom_addr or sequence; a start pulse in the DONE cycle -> ignored.
REQ-039 rst_n=0 for one cycle during the 6th SEND -> all outputs at their reset values the next cycle; a subsequent start streams the full message from 0x41.

Source files
------------

// File: rtl/msg_sequencer.sv
// -----------------------------------------------------------------------------
// msg_sequencer
//
// Streams a fixed-length message out of a combinational character ROM to a
// valid/ready sink. One start request produces MSG_LEN characters, read from
// ROM addresses 0..MSG_LEN-1 in order, with GAP_CYCLES idle cycles between
// accepted characters and a one-cycle done pulse at the end. An abort drops
// the message at any point without a done pulse.
//
// Parameters
//   MSG_LEN     characters per message, 1..16
//   GAP_CYCLES  idle cycles between accepted characters, 0..255
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       begin a message (honoured only when idle)
//   abort       drop the current message (honoured whenever busy)
//   rom_addr    ROM character address
//   rom_data    ROM character, valid in the same cycle as rom_addr
//   tx_data     character offered to the sink
//   tx_valid    tx_data is valid
//   tx_ready    sink accepts tx_data on a rising edge with tx_valid high
//   busy        a message is in progress
//   done        one-cycle pulse when a message completes normally
//   char_count  characters accepted since the last start
// -----------------------------------------------------------------------------
module msg_sequencer #(
  parameter int MSG_LEN    = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [4:0] char_count
);

  localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);
  localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] gap_cnt;
  logic       handshake;
  logic       last_char;

  // The visible status outputs are pure decodes of the state register, so
  // they are glitch-free and take their reset values directly from IDLE.
  assign tx_valid  = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  assign handshake = tx_valid && tx_ready;
  assign last_char = (rom_addr == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign every always_comb output a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    state_next = state;

    unique case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end

      FETCH: begin
        state_next = SEND;
      end

      SEND: begin
        if (handshake) begin
          if (last_char)    state_next = DONE;
          else if (HAS_GAP) state_next = GAP;
          else              state_next = FETCH;
        end
      end

      GAP: begin
        // gap_cnt was loaded with GAP_CYCLES on entry; the cycle in which it
        // reads 1 is the last gap cycle.
        if (gap_cnt <= 8'd1) state_next = FETCH;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides every other transition once a message is running.
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      tx_data    <= '0;
      char_count <= '0;
      gap_cnt    <= '0;
    end else begin
      state <= state_next;

      unique case (state)
        IDLE: begin
          // char_count keeps the previous message's total until a new start.
          if (start) begin
            rom_addr   <= '0;
            char_count <= '0;
          end
        end

        FETCH: begin
          if (!abort) tx_data <= rom_data;
        end

        SEND: begin
          // An accepted character is counted even in an abort cycle: the
          // sink has already taken it.
          if (handshake) char_count <= char_count + 5'd1;

          // Address advance stops at the last character, so rom_addr never
          // leaves 0..MSG_LEN-1.
          if (handshake && !abort && !last_char) begin
            rom_addr <= rom_addr + 4'd1;
            if (HAS_GAP) gap_cnt <= GAP_LOAD;
          end
        end

        GAP: begin
          if (abort)                gap_cnt <= '0;
          else if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end

        DONE: begin
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_msg_sequencer
//
// Three instances share one set of inputs: the default configuration, a
// zero-gap build, and a single-character build (MSG_LEN=1, GAP_CYCLES=3).
// Each has its own copy of the "ASSIGNMENT" ROM. Cycle c is the clock period
// that begins with the c-th rising edge after a start request's cycle 0;
// inputs are driven just after that edge and outputs are sampled on the
// falling edge of the same period.
// -----------------------------------------------------------------------------
module tb_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tx_ready = 1'b0;

  logic [3:0] rom_addr,   rom_addr_g0,   rom_addr_l1;
  logic [7:0] rom_data,   rom_data_g0,   rom_data_l1;
  logic [7:0] tx_data,    tx_data_g0,    tx_data_l1;
  logic       tx_valid,   tx_valid_g0,   tx_valid_l1;
  logic       busy,       busy_g0,       busy_l1;
  logic       done,       done_g0,       done_l1;
  logic [4:0] char_count, char_count_g0, char_count_l1;

  logic [7:0] msg [10] = '{8'h41, 8'h53, 8'h53, 8'h49, 8'h47,
                           8'h4E, 8'h4D, 8'h45, 8'h4E, 8'h54};
  logic [7:0] rom [16];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_buf [32];
  int         rx_n;
  int         done_cnt;

  always #5 clk = ~clk;

  assign rom_data    = rom[rom_addr];
  assign rom_data_g0 = rom[rom_addr_g0];
  assign rom_data_l1 = rom[rom_addr_l1];

  msg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .char_count(char_count)
  );

  msg_sequencer #(.MSG_LEN(10), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_addr(rom_addr_g0), .rom_data(rom_data_g0), .tx_data(tx_data_g0),
    .tx_valid(tx_valid_g0), .tx_ready(tx_ready), .busy(busy_g0), .done(done_g0),
    .char_count(char_count_g0)
  );

  msg_sequencer #(.MSG_LEN(1), .GAP_CYCLES(3)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_addr(rom_addr_l1), .rom_data(rom_data_l1), .tx_data(tx_data_l1),
    .tx_valid(tx_valid_l1), .tx_ready(tx_ready), .busy(busy_l1), .done(done_l1),
    .char_count(char_count_l1)
  );

  typedef struct {
    bit         start;
    bit         ready;
    bit         ev;     // main: tx_valid
    logic [7:0] ed;     // main: tx_data when valid
    logic [3:0] ea;     // main: rom_addr when valid
    bit         eb;     // main: busy
    bit         edn;    // main: done
    logic [4:0] ec;     // main: char_count
    bit         g0v;
    logic [7:0] g0d;
    bit         g0dn;
    bit         l1v;
    bit         l1dn;
    logic [4:0] l1c;
  } vec_t;

  vec_t vecs [42];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock period: drive inputs after the edge, sample at the falling edge,
  // and log accepted characters and done pulses of the main instance.
  task automatic cyc(input logic rn, input logic st, input logic ab, input logic rd);
    @(posedge clk);
    #1;
    rst_n    = rn;
    start    = st;
    abort    = ab;
    tx_ready = rd;
    @(negedge clk);
    if (tx_valid && tx_ready) begin
      if (rx_n < 32) rx_buf[rx_n] = tx_data;
      rx_n++;
    end
    if (done) done_cnt++;
  endtask

  task automatic clear_rx();
    for (int i = 0; i < 32; i++) rx_buf[i] = 8'h00;
    rx_n     = 0;
    done_cnt = 0;
  endtask

  task automatic run_to_done(input logic st, input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) cyc(1'b1, st, 1'b0, 1'b1);
  endtask

  task automatic verify_msg(input string tag);
    check({tag, "_rx_count"}, rx_n, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_char%0d", tag, i), rx_buf[i], msg[i]);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_char_count"}, char_count, 5'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = (i < 10) ? msg[i] : 8'hFF;
    clear_rx();

    // ---------------- reset, with start and abort asserted ----------------
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_tx_valid",   tx_valid,   1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_done",       done,       1'b0);
    check("rst_tx_data",    tx_data,    8'h00);
    check("rst_rom_addr",   rom_addr,   4'd0);
    check("rst_char_count", char_count, 5'd0);
    check("rst_busy_g0",    busy_g0,    1'b0);
    check("rst_busy_l1",    busy_l1,    1'b0);

    // ---------------- table: full message, all three builds ----------------
    // Main: SEND at 2+4k, DONE at 39. Zero gap: SEND at 2+2k, DONE at 21.
    // Single character: SEND at 2, DONE at 3.
    for (int c = 0; c < 42; c++) begin
      int cnt;
      vecs[c]       = '{default: '0};
      vecs[c].start = (c == 0);
      vecs[c].ready = 1'b1;
      if (c >= 2 && c <= 38 && ((c - 2) % 4) == 0) begin
        vecs[c].ev = 1'b1;
        vecs[c].ed = msg[(c - 2) / 4];
        vecs[c].ea = 4'((c - 2) / 4);
      end
      vecs[c].eb  = (c >= 1 && c <= 39);
      vecs[c].edn = (c == 39);
      cnt = 0;
      for (int k = 0; k < 10; k++) if (2 + 4 * k < c) cnt++;
      vecs[c].ec = 5'(cnt);
      if (c >= 2 && c <= 20 && (c % 2) == 0) begin
        vecs[c].g0v = 1'b1;
        vecs[c].g0d = msg[(c - 2) / 2];
      end
      vecs[c].g0dn = (c == 21);
      vecs[c].l1v  = (c == 2);
      vecs[c].l1dn = (c == 3);
      vecs[c].l1c  = (c >= 3) ? 5'd1 : 5'd0;
    end

    clear_rx();
    for (int c = 0; c < 42; c++) begin
      cyc(1'b1, vecs[c].start, 1'b0, vecs[c].ready);
      check($sformatf("a_valid_c%0d", c), tx_valid, vecs[c].ev);
      check($sformatf("a_busy_c%0d", c),  busy,     vecs[c].eb);
      check($sformatf("a_done_c%0d", c),  done,     vecs[c].edn);
      check($sformatf("a_count_c%0d", c), char_count, vecs[c].ec);
      if (vecs[c].ev) begin
        check($sformatf("a_data_c%0d", c), tx_data,  vecs[c].ed);
        check($sformatf("a_addr_c%0d", c), rom_addr, vecs[c].ea);
      end
      check($sformatf("g0_valid_c%0d", c), tx_valid_g0, vecs[c].g0v);
      check($sformatf("g0_done_c%0d", c),  done_g0,     vecs[c].g0dn);
      if (vecs[c].g0v) check($sformatf("g0_data_c%0d", c), tx_data_g0, vecs[c].g0d);
      check($sformatf("l1_valid_c%0d", c), tx_valid_l1, vecs[c].l1v);
      check($sformatf("l1_done_c%0d", c),  done_l1,     vecs[c].l1dn);
      check($sformatf("l1_count_c%0d", c), char_count_l1, vecs[c].l1c);
      if (vecs[c].l1v) check("l1_data", tx_data_l1, 8'h41);
    end
    verify_msg("a");
    check("g0_char_count", char_count_g0, 5'd10);

    // ---------------- stall on the 3rd character ----------------
    clear_rx();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 9; c++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 10; c <= 14; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("b_stall_valid_c%0d", c), tx_valid, 1'b1);
      check($sformatf("b_stall_data_c%0d", c),  tx_data,  8'h53);
      check($sformatf("b_stall_addr_c%0d", c),  rom_addr, 4'd2);
    end
    run_to_done(1'b0, 80);
    verify_msg("b");

    // ---------------- abort in GAP after 4 handshakes ----------------
    clear_rx();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 14; c++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);               // cycle 15 is GAP
    check("c_gap_busy",  busy,     1'b1);
    check("c_gap_valid", tx_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("c_abort_busy",  busy,       1'b0);
    check("c_abort_valid", tx_valid,   1'b0);
    check("c_abort_count", char_count, 5'd4);
    for (int c = 17; c <= 19; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("c_hold_count_c%0d", c), char_count, 5'd4);
      check($sformatf("c_idle_busy_c%0d", c),  busy,       1'b0);
    end
    check("c_done_pulses", done_cnt, 0);
    check("c_rx_count",    rx_n,     4);
    // Restart, then abort in the first SEND while the sink accepts.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("c_restart_valid", tx_valid, 1'b1);
    check("c_restart_data",  tx_data,  8'h41);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("c_send_abort_busy",  busy,       1'b0);
    check("c_send_abort_valid", tx_valid,   1'b0);
    check("c_send_abort_count", char_count, 5'd1);
    check("c_send_abort_done",  done_cnt,   0);

    // ---------------- start held high while busy ----------------
    clear_rx();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);               // cycle 2: SEND, sink stalls
    check("d_send_valid", tx_valid, 1'b1);
    check("d_send_addr",  rom_addr, 4'd0);
    check("d_send_data",  tx_data,  8'h41);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("d_send2_valid", tx_valid, 1'b1);
    check("d_send2_addr",  rom_addr, 4'd0);
    check("d_send2_data",  tx_data,  8'h41);
    run_to_done(1'b1, 80);                     // start also high in DONE
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("d_after_done_busy", busy, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("d_after_done_busy2",  busy,     1'b0);
    check("d_after_done_valid2", tx_valid, 1'b0);
    verify_msg("d");

    // ---------------- reset during the 6th SEND ----------------
    clear_rx();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 21; c++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);               // cycle 22 with reset low
    check("e_send6_valid", tx_valid, 1'b1);
    check("e_send6_data",  tx_data,  8'h4E);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("e_rst_valid", tx_valid,   1'b0);
    check("e_rst_busy",  busy,       1'b0);
    check("e_rst_done",  done,       1'b0);
    check("e_rst_data",  tx_data,    8'h00);
    check("e_rst_addr",  rom_addr,   4'd0);
    check("e_rst_count", char_count, 5'd0);
    check("e_rst_no_done", done_cnt, 0);
    clear_rx();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    run_to_done(1'b0, 80);
    verify_msg("e");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
